// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle timer: counts 0..P-1 and pulses bit_done on the terminal count.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] p,
  input  logic       clear,
  input  logic       enable,
  output logic       bit_done
);

  logic [5:0] cnt_r;
  logic [5:0] last_s;

  // Terminal count; a prescale of 0 behaves like 1.
  always_comb begin
    last_s = 6'd0;
    if (p == 6'd0) begin
      last_s = 6'd0;
    end else begin
      last_s = p - 6'd1;
    end
  end

  assign bit_done = enable && (cnt_r == last_s);

  // Cycle counter, restarted on state change or terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 6'd0;
    end else if (clear || !enable || bit_done) begin
      cnt_r <= 6'd0;
    end else begin
      cnt_r <= cnt_r + 6'd1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic typ);
    if (typ == PAR_ODD) begin
      return ~^d;
    end else begin
      return ^d;
    end
  endfunction

  tx_state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [5:0]            p_r;
  logic                  tx_out_r, tx_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  bit_done_s;
  logic                  accept_s;
  logic                  state_change_s;

  assign accept_s       = (state_r == IDLE) && DATA_VALID;
  assign state_change_s = (state_nxt_s != state_r);

  uart_tx_bit_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .p        (p_r),
    .clear    (state_change_s),
    .enable   (state_r != IDLE),
    .bit_done (bit_done_s)
  );

  // State and bit counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      bit_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
    end
  end

  // Shadow copies of the request so mid-frame input changes are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
      p_r       <= 6'd0;
    end else if (accept_s) begin
      data_r    <= P_DATA;
      par_en_r  <= PAR_EN;
      par_typ_r <= PAR_TYP;
      p_r       <= Prescale;
    end else begin
      data_r    <= data_r;
      par_en_r  <= par_en_r;
      par_typ_r <= par_typ_r;
      p_r       <= p_r;
    end
  end

  // Next-state and next bit index.
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        bit_cnt_nxt_s = '0;
        if (DATA_VALID) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_nxt_s   = DATA;
          bit_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_done_s && (bit_cnt_r == LAST_BIT)) begin
          state_nxt_s   = par_en_r ? PARITY : STOP;
          bit_cnt_nxt_s = '0;
        end else if (bit_done_s) begin
          bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
        end else begin
          bit_cnt_nxt_s = bit_cnt_r;
        end
      end
      PARITY: begin
        if (bit_done_s) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        bit_cnt_nxt_s = '0;
      end
    endcase
  end

  // Line level for the upcoming cycle, derived from the next state so outputs can be registered.
  always_comb begin
    tx_nxt_s   = LINE_IDLE;
    busy_nxt_s = 1'b1;
    case (state_nxt_s)
      IDLE: begin
        tx_nxt_s   = LINE_IDLE;
        busy_nxt_s = 1'b0;
      end
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = data_r[bit_cnt_nxt_s];
      PARITY:  tx_nxt_s = parity_bit(data_r, par_typ_r);
      STOP:    tx_nxt_s = LINE_IDLE;
      default: begin
        tx_nxt_s   = LINE_IDLE;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_out_r <= LINE_IDLE;
      busy_r   <= 1'b0;
    end else begin
      tx_out_r <= tx_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign TX_OUT = tx_out_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels come from a frame model built from bit rules.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rx_d;
  logic       rx_pe;
  logic       rx_fe;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_p(input int presc);
    return (presc == 0) ? 1 : presc;
  endfunction

  // Called right after the accept edge; checks every cycle of the frame plus the following idle cycle.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pen,
                              input logic ptyp, input int presc);
    logic q[$];
    int   p;
    int   ones;
    p    = eff_p(presc);
    ones = $countones(d);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    q.push_back(1'b1);
    for (int c = 0; c < q.size() * p; c++) begin
      #1;
      check($sformatf("%s busy c%0d", tag, c), Busy, 1);
      check($sformatf("%s line c%0d", tag, c), TX_OUT, q[c / p]);
      @(posedge CLK);
    end
    #1;
    check($sformatf("%s end busy", tag), Busy, 0);
    check($sformatf("%s end line", tag), TX_OUT, 1);
  endtask

  // Bench receiver: samples each bit at its centre and decodes the frame.
  task automatic rx_decode(input int presc, input logic pen, input logic ptyp,
                           output logic [7:0] d, output logic perr, output logic ferr);
    logic s[16];
    int   p;
    int   n;
    p = eff_p(presc);
    n = pen ? 11 : 10;
    for (int c = 0; c < n * p; c++) begin
      #1;
      if ((c % p) == (p / 2)) s[c / p] = TX_OUT;
      @(posedge CLK);
    end
    d = 8'h00;
    for (int i = 0; i < 8; i++) d[i] = s[i + 1];
    perr = pen ? (s[9] != ((^d) ^ ptyp)) : 1'b0;
    ferr = (s[0] != 1'b0) || (s[n - 1] != 1'b1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic ptyp, input int presc);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = 6'(presc); DATA_VALID = 1'b1;
    @(posedge CLK);
    fork
      expect_frame(tag, d, pen, ptyp, presc);
      begin @(negedge CLK); DATA_VALID = 1'b0; end
    join
  endtask

  task automatic run_loopback(input string tag, input int presc);
    @(negedge CLK);
    P_DATA = 8'h81; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'(presc); DATA_VALID = 1'b1;
    @(posedge CLK);
    fork
      expect_frame(tag, 8'h81, 1'b1, 1'b0, presc);
      rx_decode(presc, 1'b1, 1'b0, rx_d, rx_pe, rx_fe);
      begin @(negedge CLK); DATA_VALID = 1'b0; end
    join
    check({tag, " rx data"}, rx_d, 8'h81);
    check({tag, " rx perr"}, rx_pe, 0);
    check({tag, " rx ferr"}, rx_fe, 0);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1;
      check($sformatf("%s busy c%0d", tag, c), Busy, 0);
      check($sformatf("%s line c%0d", tag, c), TX_OUT, 1);
    end
  endtask

  initial begin
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = 8'h00;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd0;

    // Power-on reset, then a quiet idle line.
    check_idle("por", 3);
    @(negedge CLK); RST = 1'b0;
    check_idle("idle", 10);

    // Reset while idle.
    @(negedge CLK); RST = 1'b1;
    check_idle("rst_idle", 3);
    @(negedge CLK); RST = 1'b0;

    run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 8);
    run_frame("odd_00", 8'h00, 1'b1, 1'b1, 3);
    run_frame("nopar_ff", 8'hFF, 1'b0, 1'b0, 16);

    // Request pulsed mid-frame must be dropped.
    @(negedge CLK);
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 6'd2; DATA_VALID = 1'b1;
    @(posedge CLK);
    fork
      expect_frame("ign_first", 8'h96, 1'b1, 1'b1, 2);
      begin
        @(negedge CLK); DATA_VALID = 1'b0;
        repeat (6) @(negedge CLK);
        P_DATA = 8'h3C; DATA_VALID = 1'b1;
        @(negedge CLK); DATA_VALID = 1'b0;
      end
    join
    check_idle("ign_after", 5);

    // Held request: second frame starts after exactly one idle cycle.
    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd2; DATA_VALID = 1'b1;
    @(posedge CLK);
    fork
      expect_frame("b2b_first", 8'h3C, 1'b0, 1'b0, 2);
      begin @(negedge CLK); P_DATA = 8'hC3; end
    join
    @(posedge CLK);
    fork
      expect_frame("b2b_second", 8'hC3, 1'b0, 1'b0, 2);
      begin @(negedge CLK); DATA_VALID = 1'b0; end
    join

    // Inputs changed mid-frame must not affect the frame in flight.
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd3; DATA_VALID = 1'b1;
    @(posedge CLK);
    fork
      expect_frame("iso_first", 8'h5A, 1'b1, 1'b0, 3);
      begin
        @(negedge CLK); DATA_VALID = 1'b0;
        repeat (7) @(negedge CLK);
        P_DATA = 8'h11; Prescale = 6'd2; PAR_TYP = 1'b1;
      end
    join
    run_frame("iso_next", 8'h11, 1'b1, 1'b1, 2);

    run_loopback("p0_81", 0);
    run_loopback("p1_81", 1);

    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("rnd%0d", i), 8'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 6)));
    end

    // Reset in the middle of a frame aborts it cleanly.
    @(negedge CLK);
    P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd4; DATA_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK); DATA_VALID = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    check("mid busy before rst", Busy, 1);
    @(negedge CLK); RST = 1'b1;
    check_idle("rst_mid", 3);
    @(negedge CLK); RST = 1'b0;
    check_idle("after_rst", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
